pwm_gate_demodulator: RTL
=========================

Name: pwm_gate_demodulator

Overview:
- Receive-side companion to the 3-level phase-shifted modulator.
- Watches the three H-bridge gate pairs and the carrier period marker.
- Measures each bridge's gate high-time over one full carrier period and reconstructs the per-cell modulation value and the 3-cell sum.
- Used for closed-loop monitoring, fault detection and self-check of the gating path.

Parameters:
- W, 16: carrier counter width. One carrier period is 2^W clocks. Each carrier visits every signed W-bit code exactly once per period.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- gate1  input  2  Level-1 H-bridge gate pair; bit0 is the measured leg
- gate2  input  2  Level-2 H-bridge gate pair
- gate3  input  2  Level-3 H-bridge gate pair
- period_sync  input  1  one-cycle pulse, high in the cycle the carrier counter equals 0
- clr_flags  input  1  synchronous clear of sticky flags
- duty1, duty2, duty3  output  W+1 each  high-cycle counts of the last complete period, range 0..2^W
- mod_est1, mod_est2, mod_est3  output  W+1 signed each  duty minus 2^(W-1)
- mod_sum  output  W+3 signed  mod_est1 + mod_est2 + mod_est3
- valid  output  1  one-cycle pulse when all results update
- period_err  output  1  one-cycle pulse when a sync arrives early
- sync_lost  output  1  sticky; no sync within 2^W cycles
- leg_mismatch  output  3  sticky; bit i set when gate(i+1)[0] != gate(i+1)[1]

Behaviour:
- Reset (rst low, asynchronous): every output is 0, all counters are 0, and the FSM is in IDLE. Release is synchronous to clk.
- Input stage: gates and period_sync are registered once into gate_q and sync_q. All logic below operates on the registered values.
- Window definition: 2^W consecutive samples, starting with the sample where sync_q=1.
- cyc counter: W bits, counts samples within the window.
- FSM states:
  - IDLE: wait for sync_q=1. On sync_q=1: cyc<=1, cnt_i<=gate_q_i[0], go to MEASURE.
  - MEASURE, sync_q=0 and cyc<2^W-1... more precisely, cyc not at 2^W: cyc+=1, cnt_i+=gate_q_i[0].
  - MEASURE, sync_q=1 and cyc==2^W (full window): publish cnt_i to duty_i, compute mod_est_i and mod_sum, pulse valid. Restart the window with the current sample (cyc<=1, cnt_i<=gate_q_i[0]).
  - MEASURE, sync_q=1 and cyc<2^W (early sync): pulse period_err, discard counts, restart the window. Outputs hold.
  - MEASURE, sync_q=0 and cyc==2^W (missing sync): set sync_lost, go to IDLE. Outputs hold.
- cyc and cnt_i are W+1 bits so that 2^W is representable without wrap.
- Latency: valid asserts after the second rising edge following the edge that samples period_sync high. duty/mod_est/mod_sum update in the same cycle as valid.
- Arithmetic:
  - mod_est_i = duty_i - 2^(W-1), two's complement, W+1 bits, range -2^(W-1)..+2^(W-1).
  - mod_sum is sign-extended to W+3 bits; no saturation.
- Mismatch check: leg_mismatch[i] is set in any cycle gate_q_i[0]!=gate_q_i[1], in both IDLE and MEASURE. It does not affect measurement.
- clr_flags clears sync_lost and leg_mismatch.
  - If clr_flags coincides with a new set event, the set wins.
  - clr_flags has no effect on duty/mod_est/valid.
- Reset mid-window: all state and outputs go to 0 immediately. After release, the first valid requires two syncs.

Test Plan (W=6, period 64):
- Reset asserted, then released with no sync -> all outputs 0, valid never asserts, sync_lost=0 until 64 cycles pass. Then sync_lost stays 0 because the FSM is in IDLE and the missing-sync check only runs in MEASURE.
- Gates 2'b11 constant, sync every 64 cycles -> after the 2nd sync: duty1..3=64, mod_est=+32, mod_sum=+96, valid a single cycle. Repeats every 64 cycles.
- Gates driven by a model comparator (mod > t, sawtooth t=cont-32): mod1=10, mod2=-5, mod3=31 -> duty=42/27/63, mod_est=10/-5/31, mod_sum=36. Gates 2'b00 -> duty=0, mod_est=-32.
- Sync at cycle 40 of a window -> period_err pulses once, no valid, outputs hold. The next 64-cycle window produces valid with correct counts.
- Sync withheld after an open window -> sync_lost=1 at cycle 64 and the FSM returns to IDLE. Syncs resume -> valid on the 2nd resumed sync. clr_flags -> sync_lost=0.
- gate2=2'b01 for one cycle -> leg_mismatch=3'b010 sticky, duty2 still counts bit0. Pulse rst low mid-window -> all outputs 0 immediately.

Source files
------------

// File: rtl/pwm_gate_demodulator.sv
`default_nettype none
// ============================================================================
// Module   : pwm_gate_demodulator
// Brief    : Measures per-bridge gate high-time over one carrier period and
//            rebuilds the per-cell modulation value and the 3-cell sum.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_gate_demodulator #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          gate1,
  input  logic [1:0]          gate2,
  input  logic [1:0]          gate3,
  input  logic                period_sync,
  input  logic                clr_flags,
  output logic [W:0]          duty1,
  output logic [W:0]          duty2,
  output logic [W:0]          duty3,
  output logic signed [W:0]   mod_est1,
  output logic signed [W:0]   mod_est2,
  output logic signed [W:0]   mod_est3,
  output logic signed [W+2:0] mod_sum,
  output logic                valid,
  output logic                period_err,
  output logic                sync_lost,
  output logic [2:0]          leg_mismatch
);

  localparam logic [W:0] c_full = {1'b1, {W{1'b0}}};
  localparam logic [W:0] c_half = {2'b01, {(W-1){1'b0}}};
  localparam logic [W:0] c_one  = {{W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  logic [1:0]          w_gate_in [3];
  logic [1:0]          r_gate_q  [3];
  logic                r_sync_q;
  state_t              r_state;
  logic [W:0]          r_cyc;
  logic [W:0]          r_cnt [3];
  logic [W:0]          r_pub [3];
  logic                r_pub_pend;
  logic [2:0]          w_leg;
  logic [2:0]          w_mis;
  logic signed [W:0]   w_est [3];
  logic signed [W+2:0] w_ext [3];
  logic signed [W+2:0] w_sum;
  logic                w_full;
  logic                w_lost_set;

  assign w_gate_in[0] = gate1;
  assign w_gate_in[1] = gate2;
  assign w_gate_in[2] = gate3;

  // Single input register stage; everything downstream sees only gate_q/sync_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) r_gate_q[i] <= 2'b00;
      r_sync_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) r_gate_q[i] <= w_gate_in[i];
      r_sync_q <= period_sync;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cell
      assign w_leg[gi] = r_gate_q[gi][0];
      assign w_mis[gi] = r_gate_q[gi][0] ^ r_gate_q[gi][1];
      // Modular subtract: duty=2^W wraps negative as W+1 signed but lands on +2^(W-1).
      assign w_est[gi] = $signed(r_pub[gi] - c_half);
      assign w_ext[gi] = {{2{w_est[gi][W]}}, w_est[gi]};
    end
  endgenerate

  assign w_sum      = w_ext[0] + w_ext[1] + w_ext[2];
  assign w_full     = (r_cyc == c_full);
  assign w_lost_set = (r_state == S_MEASURE) && !r_sync_q && w_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_pub_pend <= 1'b0;
      period_err <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
        r_pub[i] <= '0;
      end
    end else begin
      r_pub_pend <= 1'b0;
      period_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_sync_q) begin
            r_state <= S_MEASURE;
            r_cyc   <= c_one;
            for (int i = 0; i < 3; i++) r_cnt[i] <= {{W{1'b0}}, w_leg[i]};
          end
        end
        S_MEASURE: begin
          if (r_sync_q) begin
            // Full window publishes; an early sync throws the partial counts away.
            if (w_full) begin
              r_pub_pend <= 1'b1;
              for (int i = 0; i < 3; i++) r_pub[i] <= r_cnt[i];
            end else begin
              period_err <= 1'b1;
            end
            r_cyc <= c_one;
            for (int i = 0; i < 3; i++) r_cnt[i] <= {{W{1'b0}}, w_leg[i]};
          end else if (w_full) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
          end else begin
            r_cyc <= r_cyc + c_one;
            for (int i = 0; i < 3; i++) r_cnt[i] <= r_cnt[i] + {{W{1'b0}}, w_leg[i]};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clr_flags takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_lost    <= 1'b0;
      leg_mismatch <= 3'b000;
    end else begin
      sync_lost    <= (sync_lost & ~clr_flags) | w_lost_set;
      leg_mismatch <= (leg_mismatch & ~{3{clr_flags}}) | w_mis;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= 1'b0;
      duty1    <= '0;
      duty2    <= '0;
      duty3    <= '0;
      mod_est1 <= '0;
      mod_est2 <= '0;
      mod_est3 <= '0;
      mod_sum  <= '0;
    end else begin
      valid <= r_pub_pend;
      if (r_pub_pend) begin
        duty1    <= r_pub[0];
        duty2    <= r_pub[1];
        duty3    <= r_pub[2];
        mod_est1 <= w_est[0];
        mod_est2 <= w_est[1];
        mod_est3 <= w_est[2];
        mod_sum  <= w_sum;
      end
    end
  end

endmodule
`default_nettype wire
